debug_uart_tx: RTL and testbench

Debug snapshot transmitter for the 5-stage MIPS pipeline. On a trigger it latches the pipeline's exported debug state (PC, the 32-entry register file, 10 data-memory words) and serialises it to a host as one framed UART 8N1 byte stream. It sits beside `Pipeline`, consuming its flat debug buses, and drives the board's UART TX pin. The snapshot is captured in one cycle, so the pipeline never stalls while the frame is sent.

---
 rtl/debug_uart_tx.sv | 163 ++++++++++++++++
 tb/tb_debug_uart_tx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/debug_uart_tx.sv
// Debug snapshot transmitter: captures PC, register file and data memory on a
// trigger and sends them as one 171-byte UART 8N1 frame.
module debug_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          trigger,
    input  logic [9:0]    pc,
    input  logic [1023:0] registers,
    input  logic [319:0]  memories,
    output logic          tx,
    output logic          busy,
    output logic          done
);
    localparam int unsigned       BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]        LAST_BYTE = 8'd170;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        byte_idx_q, byte_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [9:0]        pc_snap_q;
    logic [1023:0]     regs_snap_q;
    logic [319:0]      mem_snap_q;

    logic              accept;
    logic [7:0]        cur_byte;
    logic [6:0]        reg_off;
    logic [5:0]        mem_off;

    assign accept = trigger && !busy_q;

    // Words go out MSB byte first; within a word, flipping the two low offset
    // bits turns frame order into little-endian bit position.
    always_comb begin
        reg_off = 7'(byte_idx_q - 8'd3);
        mem_off = 6'(byte_idx_q - 8'd131);
        if (byte_idx_q == 8'd0) begin
            cur_byte = HEADER;
        end else if (byte_idx_q == 8'd1) begin
            cur_byte = {6'b0, pc_snap_q[9:8]};
        end else if (byte_idx_q == 8'd2) begin
            cur_byte = pc_snap_q[7:0];
        end else if (byte_idx_q < 8'd131) begin
            cur_byte = regs_snap_q[{reg_off ^ 7'd3, 3'b000} +: 8];
        end else begin
            cur_byte = mem_snap_q[{mem_off ^ 6'd3, 3'b000} +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d    = START;
                    busy_d     = 1'b1;
                    tx_d       = 1'b0;
                    baud_d     = '0;
                    bit_cnt_d  = '0;
                    byte_idx_d = '0;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d    = '0;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                    tx_d      = cur_byte[0];
                    shift_d   = {1'b0, cur_byte[7:1]};
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d    = IDLE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        byte_idx_d = '0;
                    end else begin
                        state_d    = START;
                        byte_idx_d = byte_idx_q + 8'd1;
                        tx_d       = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Snapshot needs no reset; it is only read while a frame is in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_snap_q   <= pc;
            regs_snap_q <= registers;
            mem_snap_q  <= memories;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed bench for debug_uart_tx: frame content, timing, snapshot isolation,
// busy-trigger handling and asynchronous reset.
module tb_debug_uart_tx;
    localparam int unsigned CPB    = 4;
    localparam int unsigned FRAME  = 1710 * CPB;
    localparam logic [9:0]  PC_VAL = 10'h2C3;

    logic          clk;
    logic          reset;
    logic          trigger;
    logic          trig87;
    logic [9:0]    pc;
    logic [1023:0] registers;
    logic [319:0]  memories;
    logic          tx, busy, done;
    logic          tx87, busy87, done87;

    int            n_tests;
    int            n_fail;
    logic [7:0]    exp_bytes [171];
    logic [7:0]    rx_bytes  [171];
    logic          line87    [1740];

    debug_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
        .clk(clk), .reset(reset), .trigger(trigger), .pc(pc),
        .registers(registers), .memories(memories),
        .tx(tx), .busy(busy), .done(done)
    );

    debug_uart_tx dut87 (
        .clk(clk), .reset(reset), .trigger(trig87), .pc(pc),
        .registers(registers), .memories(memories),
        .tx(tx87), .busy(busy87), .done(done87)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_inputs();
        pc = PC_VAL;
        for (int k = 0; k < 32; k++) registers[32*k +: 32] = 32'h01000000 * k + k;
        for (int m = 0; m < 10; m++) memories[32*m +: 32] = 32'hDEAD0000 + m;
    endtask

    // One frame on the CPB=4 instance; c counts cycles after the accept edge.
    task automatic do_frame(input string name, input bit hold, input bit scramble);
        int busy_n;
        int done_n;
        int done_at;
        int frame_err;
        logic [9:0] bits;
        busy_n    = 0;
        done_n    = 0;
        done_at   = -1;
        frame_err = 0;
        bits      = '0;
        @(negedge clk);
        trigger = 1'b1;
        for (int c = 0; c <= int'(FRAME) + 1; c++) begin
            @(negedge clk);
            if (c == 0 && !hold) trigger = 1'b0;
            if (scramble && c == 5) registers = '1;
            if (c <= int'(FRAME) && busy === 1'b1) busy_n++;
            if (done === 1'b1) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
            if (c < int'(FRAME) && (c % CPB) == 2) begin
                bits[(c / CPB) % 10] = tx;
                if ((c / CPB) % 10 == 9) begin
                    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) frame_err++;
                    rx_bytes[(c / CPB) / 10] = bits[8:1];
                end
            end
            if (c == int'(FRAME)) begin
                check({name, " tx at done"}, 32'(tx), 32'd1);
                check({name, " busy at done"}, 32'(busy), 32'd0);
            end
            if (c == int'(FRAME) + 1) begin
                check({name, " tx after done"}, 32'(tx), hold ? 32'd0 : 32'd1);
                check({name, " busy after done"}, 32'(busy), hold ? 32'd1 : 32'd0);
            end
        end
        check({name, " done cycle"}, 32'(done_at), 32'(FRAME));
        check({name, " done pulses"}, 32'(done_n), 32'd1);
        check({name, " busy cycles"}, 32'(busy_n), 32'(FRAME));
        check({name, " framing errors"}, 32'(frame_err), 32'd0);
        for (int b = 0; b < 171; b++)
            check($sformatf("%s byte %0d", name, b), 32'(rx_bytes[b]), 32'(exp_bytes[b]));
    endtask

    initial begin
        int low_len;
        int idle_low;
        logic [7:0] b0, b1;
        logic [31:0] w;
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b1;
        trigger  = 1'b0;
        trig87   = 1'b0;
        registers = '0;
        memories  = '0;
        load_inputs();

        exp_bytes[0] = 8'hA5;
        exp_bytes[1] = 8'h02;
        exp_bytes[2] = 8'hC3;
        for (int k = 0; k < 32; k++) begin
            w = 32'h01000000 * k + k;
            for (int j = 0; j < 4; j++) exp_bytes[3 + 4*k + j] = 8'((w >> (24 - 8*j)) & 32'hFF);
        end
        for (int m = 0; m < 10; m++) begin
            w = 32'hDEAD0000 + m;
            for (int j = 0; j < 4; j++) exp_bytes[131 + 4*m + j] = 8'((w >> (24 - 8*j)) & 32'hFF);
        end

        #10;
        check("reset tx", 32'(tx), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset tx87", 32'(tx87), 32'd1);
        check("reset busy87", 32'(busy87), 32'd0);
        #115;
        reset = 1'b0;

        idle_low = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_low++;
        end
        check("idle line", 32'(idle_low), 32'd0);

        do_frame("pulse", 1'b0, 1'b0);

        do_frame("snapshot", 1'b0, 1'b1);
        load_inputs();

        do_frame("hold", 1'b1, 1'b0);
        trigger = 1'b0;

        // Second frame started at the hold frame's last sample; move to byte 50, data bit 3.
        repeat ((50 * 10 + 4) * CPB + 1) @(negedge clk);
        check("byte50 bit3 line", 32'(tx), 32'(exp_bytes[50][3]));
        check("busy before reset", 32'(busy), 32'd1);
        #20;
        reset = 1'b1;
        #1;
        check("abort tx", 32'(tx), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post-abort tx idle", 32'(tx), 32'd1);
        do_frame("restart", 1'b0, 1'b0);

        @(negedge clk);
        trig87 = 1'b1;
        for (int c = 0; c < 1740; c++) begin
            @(negedge clk);
            if (c == 0) trig87 = 1'b0;
            line87[c] = tx87;
        end
        low_len = 0;
        for (int c = 0; c < 200; c++) begin
            if (line87[c] !== 1'b0) break;
            low_len++;
        end
        check("start bit length 87", 32'(low_len), 32'd87);
        for (int i = 0; i < 8; i++) begin
            b0[i] = line87[(1 + i) * 87 + 43];
            b1[i] = line87[(11 + i) * 87 + 43];
        end
        check("cpb87 byte0", 32'(b0), 32'hA5);
        check("cpb87 stop bit", 32'(line87[9 * 87 + 43]), 32'd1);
        check("cpb87 stop end", 32'(line87[10 * 87 - 1]), 32'd1);
        check("cpb87 next start", 32'(line87[10 * 87]), 32'd0);
        check("cpb87 byte1", 32'(b1), 32'h02);
        check("cpb87 busy", 32'(busy87), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
